ex_muldiv_sequencer: RTL and testbench
======================================

Name: ex_muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit and its sequencing FSM, sitting beside the single-cycle ALU in the execute stage of the 16-bit MIPS pipeline.
- Accepts one MUL/DIV operation from EX and iterates it over WIDTH cycles (shift-add multiply, restoring divide).
- Holds the pipeline stalled while it iterates and writes the architectural HI/LO registers on completion.

Parameters:
- WIDTH, 16, operand width in bits; HI/LO are each WIDTH bits and the iteration count is WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_Start  input  1  EX-stage request to issue a MUL/DIV this cycle.
- in_Op  input  1  operation select: 0 = MULTU, 1 = DIVU.
- in_A  input  WIDTH  operand A (multiplicand / dividend), from Read_Data_1.
- in_B  input  WIDTH  operand B (multiplier / divisor), from Read_Data_2.
- in_Flush  input  1  abort the in-flight operation (branch or exception flush).
- O_Stall  output  1  freeze IF/ID/EX pipeline registers.
- O_Busy  output  1  high while state is not IDLE.
- O_Done  output  1  one-cycle pulse when HI/LO have just been updated.
- O_DivByZero  output  1  high together with O_Done for a DIVU with in_B = 0.
- O_HI  output  WIDTH  HI register: product upper half or remainder.
- O_LO  output  WIDTH  LO register: product lower half or quotient.

Behaviour:
- Reset (rst = 1 at a clock edge):
  - FSM goes to IDLE.
  - O_HI, O_LO, the iteration counter and all working registers go to 0.
  - O_Done, O_DivByZero and O_Busy are 0.
  - O_Stall is 0 unless in_Start is high in the same cycle, because it is combinational (see below).
  - Reset overrides any in-flight operation.
- States: IDLE, RUN, DONE.
  - IDLE to RUN: in_Start = 1 and not (in_Op = 1 and in_B = 0). Operands are latched and the counter is cleared.
  - IDLE to DONE: in_Start = 1, in_Op = 1 and in_B = 0. This is the divide-by-zero fast path; there are no RUN cycles.
  - RUN: one iteration per cycle. After the WIDTH-th iteration the FSM moves to DONE, and HI/LO load on that same edge.
  - DONE to IDLE unconditionally, after one cycle. A new in_Start can be accepted on the next cycle.
- O_Stall = (state == IDLE and in_Start) or (state == RUN). It is combinational and deasserts in DONE, so the issuing instruction leaves EX in the cycle that O_Done is high.
- Latency for a normal operation:
  - Issue cycle plus WIDTH RUN cycles = WIDTH+1 stall cycles (17 for the default WIDTH).
  - O_Done rises in the cycle after the last RUN cycle.
- Multiply:
  - Unsigned, 2*WIDTH-bit accumulator, one multiplier bit per cycle (LSB first).
  - On completion, HI = upper WIDTH bits and LO = lower WIDTH bits.
- Divide:
  - Unsigned restoring division, one quotient bit per cycle (MSB first).
  - On completion, LO = quotient and HI = remainder.
- Divide by zero: HI = in_A, LO = all ones, and O_DivByZero = 1 for the DONE cycle only.
- in_Start while O_Busy is set is ignored; no queueing.
- in_Flush:
  - In RUN: go to IDLE next edge; HI/LO unchanged; no O_Done.
  - In DONE: no effect, because HI/LO were already committed.
  - In IDLE: blocks the issue (in_Flush wins over in_Start).
- HI/LO change only on the edge that enters DONE, or on reset.

Optional Feature:
- Macro: SIGNED_MULDIV_EN.
- When defined:
  - Adds input port in_Signed (1 bit) that selects MULT/DIV instead of MULTU/DIVU.
  - At issue, operands are converted to magnitudes and the result signs are recorded.
  - On the edge into DONE, results are negated as needed. There is no extra latency.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Divide by zero gives the same HI/LO/flag result as the unsigned case.
- When undefined: no in_Signed port, and all operations are unsigned.

Test Plan:
- Reset, then MULTU A=300 B=200 -> O_Stall high for 17 cycles, O_Done on the 18th, HI=0x0000, LO=0xEA60.
- MULTU A=0xFFFF B=0xFFFF -> HI=0xFFFE, LO=0x0001. A second in_Start during RUN is ignored: exactly one O_Done, latency unchanged.
- DIVU A=100 B=7 -> LO=0x000E, HI=0x0002, O_DivByZero=0. Then DIVU A=0x1234 B=0 -> O_Done the cycle after issue, HI=0x1234, LO=0xFFFF, O_DivByZero=1 for one cycle.
- Start MULTU, assert in_Flush on RUN cycle 5 -> FSM returns to IDLE, no O_Done, HI/LO keep prior values. A new DIVU 9/3 issued the next cycle gives LO=3, HI=0.
- Assert rst mid-RUN -> next cycle O_Busy=0, O_Stall=0, HI=LO=0.
- With SIGNED_MULDIV_EN: MULT -6 x 7 -> HI=0xFFFF, LO=0xFFD6; DIV -7/2 -> LO=0xFFFD, HI=0xFFFF.

Source files
------------

// File: rtl/ex_muldiv_sequencer.sv
// Iterative MULTU/DIVU (shift-add / restoring). WIDTH+1 stall cycles, O_Done in the cycle after; DIVU by 0 is done the cycle after issue.
// Optional macro SIGNED_MULDIV_EN adds in_Signed (MULT/DIV on magnitudes, sign fix-up on the edge into DONE).
module ex_muldiv_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_Start,
  input  logic             in_Op,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic             in_Flush,
`ifdef SIGNED_MULDIV_EN
  input  logic             in_Signed,
`endif
  output logic             O_Stall,
  output logic             O_Busy,
  output logic             O_Done,
  output logic             O_DivByZero,
  output logic [WIDTH-1:0] O_HI,
  output logic [WIDTH-1:0] O_LO
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;

  logic [CW-1:0]    r_cnt;
  logic             r_op, r_dbz;
  logic [WIDTH-1:0] r_wh, r_wl, r_b, r_hi, r_lo;
  logic             w_issue_dbz, w_ge;
  logic [WIDTH:0]   w_sum, w_shift;
  logic [WIDTH-1:0] w_addend, w_diff, w_it_hi, w_it_lo;
  logic [WIDTH-1:0] w_res_hi, w_res_lo, w_a_mag, w_b_mag;

  assign w_issue_dbz = in_Op && (in_B == '0);

  // Multiply keeps {acc, multiplier} in r_wh/r_wl; divide keeps {remainder, dividend/quotient}.
  assign w_addend = r_wl[0] ? r_b : '0;
  assign w_sum    = {1'b0, r_wh} + {1'b0, w_addend};
  assign w_shift  = {r_wh, r_wl[WIDTH-1]};
  assign w_ge     = (w_shift >= {1'b0, r_b});
  assign w_diff   = w_shift[WIDTH-1:0] - r_b;

  always_comb begin
    w_it_hi = w_sum[WIDTH:1];
    w_it_lo = {w_sum[0], r_wl[WIDTH-1:1]};
    if (r_op) begin
      w_it_hi = w_ge ? w_diff : w_shift[WIDTH-1:0];
      w_it_lo = {r_wl[WIDTH-2:0], w_ge};
    end
  end

`ifdef SIGNED_MULDIV_EN
  logic                 w_a_neg, w_b_neg, r_neg_q, r_neg_r;
  logic [2*WIDTH-1:0]   w_prod;

  assign w_a_neg = in_Signed && in_A[WIDTH-1];
  assign w_b_neg = in_Signed && in_B[WIDTH-1];
  assign w_a_mag = w_a_neg ? -in_A : in_A;
  assign w_b_mag = w_b_neg ? -in_B : in_B;
  assign w_prod  = r_neg_q ? -{w_it_hi, w_it_lo} : {w_it_hi, w_it_lo};

  // Quotient sign is the XOR of operand signs; remainder follows the dividend.
  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_op) begin
      w_res_hi = r_neg_r ? -w_it_hi : w_it_hi;
      w_res_lo = r_neg_q ? -w_it_lo : w_it_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == IDLE && w_next == RUN) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end
  end
`else
  assign w_a_mag  = in_A;
  assign w_b_mag  = in_B;
  assign w_res_hi = w_it_hi;
  assign w_res_lo = w_it_lo;
`endif

  always_comb begin
    w_next      = r_state;
    O_Stall     = 1'b0;
    O_Busy      = 1'b0;
    O_Done      = 1'b0;
    O_DivByZero = 1'b0;
    case (r_state)
      IDLE: begin
        O_Stall = in_Start;
        if (in_Start && !in_Flush) w_next = w_issue_dbz ? DONE : RUN;
      end
      RUN: begin
        O_Stall = 1'b1;
        O_Busy  = 1'b1;
        if (in_Flush)           w_next = IDLE;
        else if (r_cnt == LAST) w_next = DONE;
      end
      DONE: begin
        O_Busy      = 1'b1;
        O_Done      = 1'b1;
        O_DivByZero = r_dbz;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_op  <= 1'b0;
      r_dbz <= 1'b0;
      r_wh  <= '0;
      r_wl  <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_next == RUN) begin
            r_cnt <= '0;
            r_op  <= in_Op;
            r_dbz <= 1'b0;
            r_wh  <= '0;
            r_wl  <= in_Op ? w_a_mag : w_b_mag;
            r_b   <= in_Op ? w_b_mag : w_a_mag;
          end else if (w_next == DONE) begin
            r_dbz <= 1'b1;
            r_hi  <= in_A;
            r_lo  <= '1;
          end
        end
        RUN: begin
          if (!in_Flush) begin
            r_wh  <= w_it_hi;
            r_wl  <= w_it_lo;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
              r_hi <= w_res_hi;
              r_lo <= w_res_lo;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign O_HI = r_hi;
  assign O_LO = r_lo;
endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Bench for ex_muldiv_sequencer: directed scenarios plus random traffic against an arithmetic reference model.
module tb_ex_muldiv_sequencer;
`ifdef SIGNED_MULDIV_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif

  logic        clk, rst, in_Start, in_Op, in_Flush, in_Signed;
  logic [15:0] in_A, in_B;
  logic        O_Stall, O_Busy, O_Done, O_DivByZero;
  logic [15:0] O_HI, O_LO;

  int n_vec = 0;
  int n_err = 0;
  bit checking = 1'b0;

  ex_muldiv_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_Start(in_Start), .in_Op(in_Op),
    .in_A(in_A), .in_B(in_B), .in_Flush(in_Flush),
`ifdef SIGNED_MULDIV_EN
    .in_Signed(in_Signed),
`endif
    .O_Stall(O_Stall), .O_Busy(O_Busy), .O_Done(O_Done),
    .O_DivByZero(O_DivByZero), .O_HI(O_HI), .O_LO(O_LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference result {HI, LO} from plain integer arithmetic.
  function automatic logic [31:0] ref_res(input logic op, input logic sgn,
                                          input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, p, q, r;
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    if (!op) begin
      p = sa * sb;
      return p[31:0];
    end
    if (b == 16'h0) return {a, 16'hFFFF};
    q = sa / sb;
    r = sa % sb;
    return {r[15:0], q[15:0]};
  endfunction

  // Model: 0 = idle, 1 = iterating (m_left cycles to go), 2 = done.
  int          m_phase = 0;
  int          m_left  = 0;
  logic        m_dbz   = 1'b0;
  logic [15:0] m_hi = 16'h0, m_lo = 16'h0;
  logic [31:0] m_res = 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_hi    <= 16'h0;
      m_lo    <= 16'h0;
      m_dbz   <= 1'b0;
    end else begin
      case (m_phase)
        0: if (in_Start && !in_Flush) begin
          if (in_Op && in_B == 16'h0) begin
            m_phase <= 2;
            m_hi    <= in_A;
            m_lo    <= 16'hFFFF;
            m_dbz   <= 1'b1;
          end else begin
            m_res   <= ref_res(in_Op, SGN_EN && in_Signed, in_A, in_B);
            m_left  <= 16;
            m_phase <= 1;
            m_dbz   <= 1'b0;
          end
        end
        1: if (in_Flush) m_phase <= 0;
           else begin
             m_left <= m_left - 1;
             if (m_left == 1) begin
               m_phase <= 2;
               m_hi    <= m_res[31:16];
               m_lo    <= m_res[15:0];
             end
           end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    #2;
    if (checking) begin
      chk("stall", 32'(O_Stall), 32'((m_phase == 0 && in_Start) || m_phase == 1));
      chk("busy",  32'(O_Busy),  32'(m_phase != 0));
      chk("done",  32'(O_Done),  32'(m_phase == 2));
      chk("dbz",   32'(O_DivByZero), 32'(m_phase == 2 && m_dbz));
      chk("hi",    32'(O_HI), 32'(m_hi));
      chk("lo",    32'(O_LO), 32'(m_lo));
    end
  end

  // Called just after a negedge; issues at once and watches ncyc cycles.
  task automatic do_op(input logic op, input logic sgn, input logic [15:0] a, input logic [15:0] b,
                       input int ncyc, input int extra_start_at, input int flush_at,
                       output int stalls, output int dones, output int done_cyc,
                       output logic [15:0] hi, output logic [15:0] lo, output logic dbz);
    in_Start = 1'b1; in_Op = op; in_Signed = sgn; in_A = a; in_B = b; in_Flush = 1'b0;
    stalls = 0; dones = 0; done_cyc = -1; hi = 16'hxxxx; lo = 16'hxxxx; dbz = 1'bx;
    for (int c = 0; c < ncyc; c++) begin
      #1;
      if (O_Stall) stalls++;
      if (O_Done) begin
        dones++;
        if (done_cyc < 0) begin
          done_cyc = c; hi = O_HI; lo = O_LO; dbz = O_DivByZero;
        end
      end
      @(negedge clk);
      in_Start = (c + 1 == extra_start_at);
      in_Flush = (c + 1 == flush_at);
    end
  endtask

  int          st, dn, dc;
  logic [15:0] h, l;
  logic        z;

  initial begin
    rst = 1'b1; in_Start = 1'b0; in_Op = 1'b0; in_Flush = 1'b0; in_Signed = 1'b0;
    in_A = 16'h0; in_B = 16'h0;

    chk("ref_mul",     ref_res(1'b0, 1'b0, 16'd300, 16'd200), 32'h0000EA60);
    chk("ref_mul_max", ref_res(1'b0, 1'b0, 16'hFFFF, 16'hFFFF), 32'hFFFE0001);
    chk("ref_div",     ref_res(1'b1, 1'b0, 16'd100, 16'd7), 32'h0002000E);
    chk("ref_smul",    ref_res(1'b0, 1'b1, 16'hFFFA, 16'h0007), 32'hFFFFFFD6);
    chk("ref_sdiv",    ref_res(1'b1, 1'b1, 16'hFFF9, 16'h0002), 32'hFFFFFFFD);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;
    #1;
    chk("rst_hi", 32'(O_HI), 32'h0);
    chk("rst_lo", 32'(O_LO), 32'h0);
    chk("rst_busy", 32'(O_Busy), 32'h0);
    chk("rst_stall", 32'(O_Stall), 32'h0);
    @(negedge clk);

    do_op(1'b0, 1'b0, 16'd300, 16'd200, 20, -1, -1, st, dn, dc, h, l, z);
    chk("mul1_stalls", 32'(st), 32'd17);
    chk("mul1_done_cyc", 32'(dc), 32'd17);
    chk("mul1_hi", 32'(h), 32'h0000);
    chk("mul1_lo", 32'(l), 32'hEA60);

    do_op(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 20, 3, -1, st, dn, dc, h, l, z);
    chk("mul2_dones", 32'(dn), 32'd1);
    chk("mul2_stalls", 32'(st), 32'd17);
    chk("mul2_done_cyc", 32'(dc), 32'd17);
    chk("mul2_hi", 32'(h), 32'hFFFE);
    chk("mul2_lo", 32'(l), 32'h0001);

    do_op(1'b1, 1'b0, 16'd100, 16'd7, 20, -1, -1, st, dn, dc, h, l, z);
    chk("div1_lo", 32'(l), 32'h000E);
    chk("div1_hi", 32'(h), 32'h0002);
    chk("div1_dbz", 32'(z), 32'h0);

    do_op(1'b1, 1'b0, 16'h1234, 16'h0000, 4, -1, -1, st, dn, dc, h, l, z);
    chk("dbz_done_cyc", 32'(dc), 32'd1);
    chk("dbz_dones", 32'(dn), 32'd1);
    chk("dbz_hi", 32'(h), 32'h1234);
    chk("dbz_lo", 32'(l), 32'hFFFF);
    chk("dbz_flag", 32'(z), 32'h1);

    do_op(1'b0, 1'b0, 16'd55, 16'd77, 6, -1, 5, st, dn, dc, h, l, z);
    repeat (2) begin
      #1;
      chk("flush_no_done", 32'(O_Done), 32'h0);
      @(negedge clk);
    end
    chk("flush_hi", 32'(O_HI), 32'h1234);
    chk("flush_lo", 32'(O_LO), 32'hFFFF);
    do_op(1'b0, 1'b0, 16'd55, 16'd77, 6, -1, 5, st, dn, dc, h, l, z);
    do_op(1'b1, 1'b0, 16'd9, 16'd3, 20, -1, -1, st, dn, dc, h, l, z);
    chk("div93_done_cyc", 32'(dc), 32'd17);
    chk("div93_lo", 32'(l), 32'h0003);
    chk("div93_hi", 32'(h), 32'h0000);

    do_op(1'b0, 1'b0, 16'd1000, 16'd999, 4, -1, -1, st, dn, dc, h, l, z);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(O_Busy), 32'h0);
    chk("midrst_stall", 32'(O_Stall), 32'h0);
    chk("midrst_hi", 32'(O_HI), 32'h0);
    chk("midrst_lo", 32'(O_LO), 32'h0);
    @(negedge clk);

    if (SGN_EN) begin
      do_op(1'b0, 1'b1, 16'hFFFA, 16'h0007, 20, -1, -1, st, dn, dc, h, l, z);
      chk("smul_hi", 32'(h), 32'hFFFF);
      chk("smul_lo", 32'(l), 32'hFFD6);
      do_op(1'b1, 1'b1, 16'hFFF9, 16'h0002, 20, -1, -1, st, dn, dc, h, l, z);
      chk("sdiv_lo", 32'(l), 32'hFFFD);
      chk("sdiv_hi", 32'(h), 32'hFFFF);
    end

    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 399) == 0);
      in_Start  = ($urandom_range(0, 3) == 0);
      in_Op     = 1'($urandom_range(0, 1));
      in_Signed = 1'($urandom_range(0, 1));
      in_A      = 16'($urandom);
      in_B      = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      in_Flush  = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    rst = 1'b0; in_Start = 1'b0; in_Flush = 1'b0;
    repeat (20) @(negedge clk);
    #3;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
